// File: rtl/score_pkg.sv
// Shared types and geometry for the score digit writer: FSM states,
// glyph/digit dimensions and the background frame-buffer address width.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VB,
      WRITE,
      FIN
   } state_t;

   localparam int unsigned GLYPH_W         = 5;
   localparam int unsigned GLYPH_H         = 7;
   localparam int unsigned SCALE           = 2;
   localparam int unsigned DIGIT_W         = GLYPH_W * SCALE;
   localparam int unsigned DIGIT_H         = GLYPH_H * SCALE;
   localparam int unsigned PIXELS_PER_PASS = 2 * DIGIT_W * DIGIT_H;
   localparam int unsigned BG_FB_ADDR_W    = 17;

   // Scores above 9 cannot be shown with a single digit, so they saturate.
   function automatic logic [3:0] clamp_digit(input logic [3:0] value);
      return (value > 4'd9) ? 4'd9 : value;
   endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// 5x7 bitmap font for digits 0-9; returns one glyph row, bit 4 = leftmost column.
module digit_glyph_rom
   import score_pkg::*;
(
   input  logic [3:0] digit,
   input  logic [2:0] row,
   output logic [4:0] row_bits
);

   logic [GLYPH_W*GLYPH_H-1:0] glyph;

   // Top glyph row sits in the most significant five bits.
   always_comb begin
      glyph = '0;
      case (digit)
         4'd0: glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
         4'd1: glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         4'd2: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
         4'd3: glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
         4'd4: glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
         4'd5: glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
         4'd6: glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
         4'd7: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
         4'd8: glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
         4'd9: glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
         default: glyph = '0;
      endcase
      row_bits = '0;
      case (row)
         3'd0: row_bits = glyph[34:30];
         3'd1: row_bits = glyph[29:25];
         3'd2: row_bits = glyph[24:20];
         3'd3: row_bits = glyph[19:15];
         3'd4: row_bits = glyph[14:10];
         3'd5: row_bits = glyph[9:5];
         3'd6: row_bits = glyph[4:0];
         default: row_bits = '0;
      endcase
   end

endmodule

// File: rtl/fb_score_writer.sv
// Rasterises both 2x-scaled score digits into the background frame buffer, one pixel per clock.
// Define SCORE_VBLANK_GATE_EN to restrict writes to vertical blanking; otherwise vblank is ignored.
module fb_score_writer
   import score_pkg::*;
#(
   parameter int unsigned LEFT_X   = 40,
   parameter int unsigned RIGHT_X  = 270,
   parameter int unsigned DIGIT_Y  = 8,
   parameter int unsigned FB_W     = 320,
   parameter logic [11:0] FG_COLOR = 12'hFFF,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [3:0]              score_left,
   input  logic [3:0]              score_right,
   input  logic                    score_valid,
   input  logic                    vblank,
   output logic                    fb_we,
   output logic [BG_FB_ADDR_W-1:0] fb_addr,
   output logic [11:0]             fb_data,
   output logic                    busy,
   output logic                    done
);

   state_t                  state;
   logic [3:0]              digit_left, digit_right;
   logic [3:0]              pend_left, pend_right;
   logic                    pending;
   logic [3:0]              col, row;
   logic                    sel;
   logic [8:0]              pix_count;
   logic                    write_ok;
   logic                    last_pixel;
   logic [3:0]              cur_digit;
   logic [2:0]              glyph_col;
   logic [2:0]              glyph_line;
   logic [4:0]              glyph_row;
   logic [BG_FB_ADDR_W-1:0] row_base, x_base, pixel_addr;
   logic [11:0]             pixel_color;

`ifdef SCORE_VBLANK_GATE_EN
   assign write_ok = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign write_ok      = 1'b1;
`endif

   assign cur_digit  = sel ? digit_right : digit_left;
   assign glyph_col  = 3'(col / 4'(SCALE));
   assign glyph_line = 3'(row / 4'(SCALE));
   assign last_pixel = (pix_count == 9'(PIXELS_PER_PASS - 1));

   digit_glyph_rom u_rom (
      .digit    (cur_digit),
      .row      (glyph_line),
      .row_bits (glyph_row)
   );

   // Address and colour of the pixel the counters currently point at.
   always_comb begin
      row_base    = (BG_FB_ADDR_W'(DIGIT_Y) + BG_FB_ADDR_W'(row)) * BG_FB_ADDR_W'(FB_W);
      x_base      = sel ? BG_FB_ADDR_W'(RIGHT_X) : BG_FB_ADDR_W'(LEFT_X);
      pixel_addr  = row_base + x_base + BG_FB_ADDR_W'(col);
      pixel_color = glyph_row[3'(GLYPH_W - 1) - glyph_col] ? FG_COLOR : BG_COLOR;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pending     <= 1'b0;
         digit_left  <= '0;
         digit_right <= '0;
         pend_left   <= '0;
         pend_right  <= '0;
         col         <= '0;
         row         <= '0;
         sel         <= 1'b0;
         pix_count   <= '0;
      end else begin
         done <= 1'b0;
         // Requests arriving mid-pass are parked; the newest one wins.
         if (score_valid && state != IDLE) begin
            pending    <= 1'b1;
            pend_left  <= clamp_digit(score_left);
            pend_right <= clamp_digit(score_right);
         end
         case (state)
            IDLE: begin
               fb_we <= 1'b0;
               if (score_valid) begin
                  digit_left  <= clamp_digit(score_left);
                  digit_right <= clamp_digit(score_right);
                  busy        <= 1'b1;
                  state       <= WAIT_VB;
               end
            end
            WAIT_VB, WRITE: begin
               fb_addr <= pixel_addr;
               fb_data <= pixel_color;
               if (write_ok) begin
                  fb_we     <= 1'b1;
                  pix_count <= last_pixel ? 9'd0 : pix_count + 9'd1;
                  state     <= last_pixel ? FIN : WRITE;
                  if (col == 4'(DIGIT_W - 1)) begin
                     col <= '0;
                     if (row == 4'(DIGIT_H - 1)) begin
                        row <= '0;
                        sel <= ~sel;
                     end else begin
                        row <= row + 4'd1;
                     end
                  end else begin
                     col <= col + 4'd1;
                  end
               end else begin
                  fb_we <= 1'b0;
               end
            end
            FIN: begin
               fb_we <= 1'b0;
               done  <= 1'b1;
               if (pending || score_valid) begin
                  digit_left  <= score_valid ? clamp_digit(score_left) : pend_left;
                  digit_right <= score_valid ? clamp_digit(score_right) : pend_right;
                  pending     <= 1'b0;
                  busy        <= 1'b1;
                  state       <= WAIT_VB;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_score_writer.sv
// Directed bench for fb_score_writer: a pixel scoreboard filled on each request and drained on fb_we.
module tb_fb_score_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  score_left = '0;
   logic [3:0]  score_right = '0;
   logic        score_valid = 1'b0;
   logic        vblank = 1'b1;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic [11:0] fb_data;
   logic        busy;
   logic        done;

   fb_score_writer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .score_left  (score_left),
      .score_right (score_right),
      .score_valid (score_valid),
      .vblank      (vblank),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [16:0] addr;
      logic [11:0] data;
   } pix_t;

   pix_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          pass_writes = 0;
   int          first_we_cyc = -1;
   int          last_we_cyc = -1;
   int          done_cyc = -1;
   logic [16:0] first_addr = '0;
   logic [16:0] last_addr = '0;
   bit          done_flag = 1'b0;
   bit          model_busy = 1'b0;
   bit          model_pend = 1'b0;
   logic [3:0]  pend_l = '0;
   logic [3:0]  pend_r = '0;

   function automatic logic [4:0] font_row(input int d, input int r);
      logic [34:0] g;
      case (d)
         0: g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
         1: g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         2: g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
         3: g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
         4: g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
         5: g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
         6: g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
         7: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
         8: g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
         9: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
         default: g = '0;
      endcase
      return g[(6 - r) * 5 +: 5];
   endfunction

   function automatic logic [16:0] exp_addr(input int s, input int r, input int c);
      return 17'((8 + r) * 320 + (s != 0 ? 270 : 40) + c);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_pass(input logic [3:0] l, input logic [3:0] r);
      int   d;
      logic [4:0] fr;
      pix_t p;
      for (int s = 0; s < 2; s++) begin
         d = (s == 0) ? ((l > 9) ? 9 : int'(l)) : ((r > 9) ? 9 : int'(r));
         for (int y = 0; y < 14; y++) begin
            for (int x = 0; x < 10; x++) begin
               fr     = font_row(d, y / 2);
               p.addr = exp_addr(s, y, x);
               p.data = fr[4 - x / 2] ? 12'hFFF : 12'h000;
               exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic monitor();
      pix_t p;
      if (fb_we === 1'b1) begin
         if (pass_writes == 0) begin
            first_we_cyc = cyc;
            first_addr   = fb_addr;
         end
         last_we_cyc = cyc;
         last_addr   = fb_addr;
         pass_writes++;
         if (exp_q.size() == 0) begin
            check_output("spurious_we", 32'(fb_we), 0);
         end else begin
            p = exp_q.pop_front();
            check_output("pix_addr", 32'(fb_addr), 32'(p.addr));
            check_output("pix_data", 32'(fb_data), 32'(p.data));
         end
      end
      if (done === 1'b1) begin
         done_cyc  = cyc;
         done_flag = 1'b1;
         if (!model_busy) begin
            check_output("spurious_done", 32'(done), 0);
         end else begin
            check_output("busy_at_done", 32'(busy), 32'(model_pend));
            check_output("queue_empty_at_done", exp_q.size(), 0);
            if (model_pend) begin
               push_pass(pend_l, pend_r);
               model_pend = 1'b0;
            end else begin
               model_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic reset_stats();
      pass_writes  = 0;
      first_we_cyc = -1;
      last_we_cyc  = -1;
   endtask

   task automatic apply_stimulus(input logic [3:0] l, input logic [3:0] r);
      bit was_busy;
      was_busy = model_busy;
      if (model_busy) begin
         model_pend = 1'b1;
         pend_l     = l;
         pend_r     = r;
      end else begin
         model_busy = 1'b1;
         push_pass(l, r);
      end
      req_cyc     = cyc;
      score_left  = l;
      score_right = r;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      if (!was_busy) begin
         check_output("busy_rise", 32'(busy), 1);
         check_output("we_low_after_req", 32'(fb_we), 0);
      end
   endtask

   task automatic wait_done(input int budget);
      done_flag = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_flag) break;
      end
      check_output("done_timeout", 32'(done_flag), 1);
   endtask

   task automatic wait_writes(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pass_writes >= n) break;
         tick();
      end
      check_output("writes_timeout", 32'(pass_writes >= n), 1);
   endtask

   task automatic check_full_pass(input string tag);
      check_output({tag, "_count"}, pass_writes, 280);
      check_output({tag, "_consecutive"}, last_we_cyc - first_we_cyc + 1, 280);
      check_output({tag, "_done_latency"}, done_cyc - last_we_cyc, 1);
   endtask

   initial begin
      // Reset held for three cycles with vblank high.
      reset_n = 1'b0;
      vblank  = 1'b1;
      repeat (3) tick();
      check_output("rst_fb_we", 32'(fb_we), 0);
      check_output("rst_fb_addr", 32'(fb_addr), 0);
      check_output("rst_fb_data", 32'(fb_data), 0);
      check_output("rst_busy", 32'(busy), 0);
      check_output("rst_done", 32'(done), 0);
      reset_n = 1'b1;
      reset_stats();
      repeat (100) tick();
      check_output("idle_no_writes", pass_writes, 0);

      // Basic pass "3" / "7" with vblank already high.
      reset_stats();
      apply_stimulus(4'd3, 4'd7);
      wait_done(400);
      check_full_pass("pass37");
      check_output("pass37_first_we", first_we_cyc - req_cyc, 2);
      check_output("pass37_first_addr", 32'(first_addr), 2600);
      check_output("pass37_last_addr", 32'(last_addr), 6999);
      tick();
      check_output("done_one_cycle", 32'(done), 0);
      check_output("busy_low_idle", 32'(busy), 0);

`ifdef SCORE_VBLANK_GATE_EN
      // vblank drops after write 50 for 200 cycles.
      reset_stats();
      apply_stimulus(4'd4, 4'd8);
      wait_writes(50, 100);
      vblank = 1'b0;
      tick();
      check_output("gap_we_low", 32'(fb_we), 0);
      check_output("gap_addr", 32'(fb_addr), 32'(exp_addr(0, 5, 0)));
      repeat (200) tick();
      check_output("gap_no_writes", pass_writes, 50);
      check_output("gap_addr_frozen", 32'(fb_addr), 32'(exp_addr(0, 5, 0)));
      check_output("gap_busy", 32'(busy), 1);
      vblank = 1'b1;
      tick();
      check_output("gap_resume_we", 32'(fb_we), 1);
      wait_done(400);
      check_output("gap_total_writes", pass_writes, 280);
      check_output("gap_done_latency", done_cyc - last_we_cyc, 1);

      // Request outside vblank waits; first write one cycle after vblank rises.
      vblank = 1'b0;
      reset_stats();
      apply_stimulus(4'd0, 4'd9);
      repeat (5) tick();
      check_output("wait_vb_no_writes", pass_writes, 0);
      check_output("wait_vb_busy", 32'(busy), 1);
      vblank = 1'b1;
      req_cyc = cyc;
      wait_done(400);
      check_output("wait_vb_first_we", first_we_cyc - req_cyc, 1);
      check_full_pass("pass09");
`else
      // Ungated build: vblank low throughout still writes back-to-back.
      vblank = 1'b0;
      reset_stats();
      apply_stimulus(4'd4, 4'd8);
      wait_done(400);
      check_output("nogate_first_we", first_we_cyc - req_cyc, 2);
      check_full_pass("nogate");
      vblank = 1'b1;
`endif

      // Two requests during a pass: only the newest is drawn afterwards.
      reset_stats();
      apply_stimulus(4'd6, 4'd5);
      wait_writes(20, 50);
      apply_stimulus(4'd1, 4'd1);
      wait_writes(100, 200);
      apply_stimulus(4'd2, 4'd2);
      wait_done(400);
      check_output("pend_first_pass_count", pass_writes, 280);
      reset_stats();
      tick();
      check_output("pend_busy_between", 32'(busy), 1);
      wait_done(400);
      check_full_pass("pend_second");
      done_flag = 1'b0;
      repeat (50) tick();
      check_output("pend_no_third_pass", pass_writes, 280);
      check_output("pend_no_extra_done", 32'(done_flag), 0);

      // Score 12 saturates to 9.
      reset_stats();
      apply_stimulus(4'd12, 4'd3);
      wait_done(400);
      check_full_pass("clamp");

      // Request in the same cycle as done starts a new pass.
      reset_stats();
      apply_stimulus(4'd8, 4'd0);
      wait_done(400);
      reset_stats();
      apply_stimulus(4'd0, 4'd9);
      wait_done(400);
      check_output("done_cycle_req_first_we", first_we_cyc - req_cyc, 2);
      check_full_pass("done_cycle_req");

      // Reset in the middle of a pass.
      reset_stats();
      apply_stimulus(4'd5, 4'd6);
      wait_writes(30, 60);
      reset_n = 1'b0;
      tick();
      check_output("midrst_fb_we", 32'(fb_we), 0);
      check_output("midrst_fb_addr", 32'(fb_addr), 0);
      check_output("midrst_busy", 32'(busy), 0);
      check_output("midrst_done", 32'(done), 0);
      exp_q.delete();
      model_busy = 1'b0;
      model_pend = 1'b0;
      reset_n = 1'b1;
      reset_stats();
      repeat (20) tick();
      check_output("midrst_no_writes", pass_writes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fb_score_writer.md
# fb_score_writer

Writes the two player score digits into the 320x240, 12-bit background frame buffer through that SRAM's write port. On a score-change request it snapshots both scores, then rasterises each as a 2x-scaled 5x7 glyph (10x14 pixels). It writes one pixel per clock, only while the display is in vertical blanking. It sits between the game-state FSM, which produces scores, and the background SRAM, which the renderer reads for every visible pixel.

## Interface
- LEFT_X, 40: frame-buffer column of the left digit's top-left pixel
- RIGHT_X, 270: frame-buffer column of the right digit's top-left pixel
- DIGIT_Y, 8: frame-buffer row of both digits' top pixel
- FB_W, 320: frame-buffer width in pixels
- FG_COLOR, 12'hFFF: colour for glyph bit 1
- BG_COLOR, 12'h000: colour for glyph bit 0
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- score_left  input  4  left player score
- score_right  input  4  right player score
- score_valid  input  1  one-cycle request to redraw both digits
- vblank  input  1  high while the VGA scan is outside rows 0..479
- fb_we  output  1  frame-buffer write strobe
- fb_addr  output  17  frame-buffer pixel address
- fb_data  output  12  pixel colour to write
- busy  output  1  high from request acceptance until the last write
- done  output  1  one-cycle pulse the cycle after the last write

## Operation
- States:
  - IDLE: on score_valid, latch both scores, clamped (value > 9 becomes 9), then go to WAIT_VB.
  - WAIT_VB: go to WRITE when vblank=1.
  - WRITE: emit one pixel per cycle while vblank=1. When vblank=0, hold all counters and drive fb_we=0; resume from the same pixel on the next vblank=1.
  - FIN: pulse done, then go to IDLE, or to WAIT_VB if a request is pending.
- Counters:
  - col 0..9, row 0..13, sel 0..1 (0 = left digit, 1 = right digit).
  - Order: row-major within a digit; the left digit completes before the right digit.
  - One pass is 280 writes.
- Pixel mapping:
  - fb_addr = (DIGIT_Y+row)*FB_W + (sel ? RIGHT_X : LEFT_X) + col.
  - The calculation uses 17-bit unsigned arithmetic; it cannot overflow for parameters inside the 320x240 buffer.
  - Glyph bit = font[digit][row>>1][col>>1]; bit 1 gives FG_COLOR, bit 0 gives BG_COLOR.
- Pending request:
  - A score_valid arriving while busy is captured once; further requests overwrite the pending scores.
  - The current pass finishes unchanged. After FIN, a second pass draws the newest captured values.
- Reset mid-pass: all state and outputs return to reset values on the next clock edge. A partially drawn digit is left in memory.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0; state IDLE; no pending request.
- busy rises the cycle after score_valid is sampled.
- The first fb_we rises 2 cycles after score_valid if vblank is already 1; otherwise 1 cycle after vblank rises.
- fb_we, fb_addr and fb_data are registered and change together. The SRAM samples them on the following edge.
- With continuous vblank, fb_we is high for exactly 280 consecutive cycles.
- done pulses the cycle after the last fb_we. busy falls in the same cycle as done unless a pending request exists, in which case busy stays high.
- A score_valid in the same cycle as done is treated as pending and starts a new pass.

## Configuration
- SCORE_VBLANK_GATE_EN defined: writes occur only while vblank=1, as described above.
- SCORE_VBLANK_GATE_EN undefined: vblank is ignored.
  - WAIT_VB passes straight through.
  - 280 writes run back-to-back.
  - Brief tearing of the score area is accepted.

## Structure
- Shared package `score_pkg`:
  - state enum
  - GLYPH_W=5, GLYPH_H=7, SCALE=2, DIGIT_W=10, DIGIT_H=14
  - PIXELS_PER_PASS=280
  - BG_FB_ADDR_W=17
- Sub-module `digit_glyph_rom`: combinational; inputs digit[3:0], row[2:0]; output 5-bit row bitmap for digits 0-9. Bit 4 is the leftmost column.

## Test plan
- Reset with reset_n=0 for 3 cycles, vblank=1 → all outputs 0; no fb_we for 100 cycles.
- score_left=3, score_right=7, score_valid pulse, vblank=1 →
  - 280 consecutive writes
  - first address 2600, last address (8+13)*320+270+9=6999
  - written pixels match the glyphs for "3" and "7"
  - done one cycle after the last write
- vblank drops after write 50, returns 200 cycles later → fb_we=0 with address frozen at write 50's successor; writing resumes there; total writes 280.
- score_valid (1,1) during a pass, then (2,2) also during the pass → first pass completes; exactly one further pass draws "2" and "2"; busy stays high between passes.
- score_left=12 → left digit drawn as "9".
- Build without SCORE_VBLANK_GATE_EN, vblank=0 throughout, score_valid → 280 back-to-back writes starting 2 cycles after the request.
